// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer between the fetch stage and the dual-issue
// decode stage. Fetch pushes one {instr, pc, pc+4} entry per cycle. Decode
// sees the two oldest entries on slot0/slot1 and pops 0..2 of them per cycle.
// A redirect (flush_i) drops every queued entry.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [31:0]      instr_i,
   input  logic [31:0]      pc_i,
   input  logic [31:0]      pc_plus4_i,
   output logic             fetch_en_o,
   input  logic [1:0]       deq_cnt_i,
   output logic             slot0_valid_o,
   output logic [31:0]      slot0_instr_o,
   output logic [31:0]      slot0_pc_o,
   output logic [31:0]      slot0_pc4_o,
   output logic             slot1_valid_o,
   output logic [31:0]      slot1_instr_o,
   output logic [31:0]      slot1_pc_o,
   output logic [31:0]      slot1_pc4_o,
   output logic [PTR_W:0]   count_o
);

   logic [31:0]    r_instr [DEPTH];
   logic [31:0]    r_pc    [DEPTH];
   logic [31:0]    r_pc4   [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   logic             w_full;
   logic             w_accept;
   logic [PTR_W:0]   w_req;
   logic [PTR_W:0]   w_pop;
   logic [PTR_W-1:0] w_idx1;

   // Full blocks enqueue even when decode pops in the same cycle; the slot
   // only reopens once the lower count is registered.
   always_comb begin
      w_full   = (r_count == (PTR_W+1)'(DEPTH));
      w_accept = valid_i & ~w_full & ~flush_i;
   end

   // Pop size: request clamped to 2, then to the number of valid entries
   always_comb begin
      w_req = '0;
      if (deq_cnt_i[1])
         w_req = (PTR_W+1)'(2);
      else
         w_req = (PTR_W+1)'(deq_cnt_i[0]);
      w_pop = (w_req > r_count) ? r_count : w_req;
   end

   // Pointer and occupancy update; reset beats flush beats normal traffic
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head <= r_head + PTR_W'(w_pop);
         if (w_accept)
            r_tail <= r_tail + PTR_W'(1);
         r_count <= r_count + (PTR_W+1)'(w_accept) - w_pop;
      end
   end

   // Entry storage; left uncleared because occupancy gates every read
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_instr[r_tail] <= instr_i;
         r_pc[r_tail]    <= pc_i;
         r_pc4[r_tail]   <= pc_plus4_i;
      end
   end

   // Read side: combinational from registered state, invalid slots read zero
   always_comb begin
      w_idx1        = r_head + PTR_W'(1);
      fetch_en_o    = ~w_full;
      count_o       = r_count;
      slot0_valid_o = (r_count != '0);
      slot1_valid_o = (r_count >= (PTR_W+1)'(2));
      slot0_instr_o = '0;
      slot0_pc_o    = '0;
      slot0_pc4_o   = '0;
      slot1_instr_o = '0;
      slot1_pc_o    = '0;
      slot1_pc4_o   = '0;
      if (slot0_valid_o) begin
         slot0_instr_o = r_instr[r_head];
         slot0_pc_o    = r_pc[r_head];
         slot0_pc4_o   = r_pc4[r_head];
      end
      if (slot1_valid_o) begin
         slot1_instr_o = r_instr[w_idx1];
         slot1_pc_o    = r_pc[w_idx1];
         slot1_pc4_o   = r_pc4[w_idx1];
      end
   end

endmodule
